// File: rtl/usbdev_wb_arbiter.sv
// Round-robin two-master Wishbone arbiter in front of the UsbDeviceTop slave port.
// Bus lock for the whole CYC, plus a watchdog that ends hung strobes with a synthetic ACK.
module usbdev_wb_arbiter #(
    parameter int ADR_W   = 14,
    parameter int DAT_W   = 32,
    parameter int SEL_W   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             ctrlCd_clk,
    input  logic             ctrlCd_reset,
    input  logic             m0_CYC,
    input  logic             m0_STB,
    input  logic             m0_WE,
    input  logic [ADR_W-1:0] m0_ADR,
    input  logic [SEL_W-1:0] m0_SEL,
    input  logic [DAT_W-1:0] m0_DAT_MOSI,
    output logic             m0_ACK,
    output logic [DAT_W-1:0] m0_DAT_MISO,
    input  logic             m1_CYC,
    input  logic             m1_STB,
    input  logic             m1_WE,
    input  logic [ADR_W-1:0] m1_ADR,
    input  logic [SEL_W-1:0] m1_SEL,
    input  logic [DAT_W-1:0] m1_DAT_MOSI,
    output logic             m1_ACK,
    output logic [DAT_W-1:0] m1_DAT_MISO,
    output logic             s_CYC,
    output logic             s_STB,
    output logic             s_WE,
    output logic [ADR_W-1:0] s_ADR,
    output logic [SEL_W-1:0] s_SEL,
    output logic [DAT_W-1:0] s_DAT_MOSI,
    input  logic             s_ACK,
    input  logic [DAT_W-1:0] s_DAT_MISO,
    input  logic             timeout_clr,
    output logic             timeout_sticky,
    output logic [1:0]       grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       last;
    logic [7:0] wd_cnt;
    logic       wd_pend;

    logic             own0;
    logic             own1;
    logic             own;
    logic             req0;
    logic             req1;
    logic             m_cyc;
    logic             m_stb;
    logic             m_we;
    logic [ADR_W-1:0] m_adr;
    logic [SEL_W-1:0] m_sel;
    logic [DAT_W-1:0] m_dat;
    logic             ack;
    logic             wd_fire;
    logic             wd_wait;
    logic [DAT_W-1:0] rdata;

    assign own0 = (state == OWN0);
    assign own1 = (state == OWN1);
    assign own  = own0 | own1;
    assign req0 = m0_CYC & m0_STB;
    assign req1 = m1_CYC & m1_STB;

    assign m_cyc = own1 ? m1_CYC      : m0_CYC;
    assign m_stb = own1 ? m1_STB      : m0_STB;
    assign m_we  = own1 ? m1_WE       : m0_WE;
    assign m_adr = own1 ? m1_ADR      : m0_ADR;
    assign m_sel = own1 ? m1_SEL      : m0_SEL;
    assign m_dat = own1 ? m1_DAT_MOSI : m0_DAT_MOSI;

    // Strobe is withheld from the slave on the synthetic-ACK cycle.
    assign s_CYC      = own & m_cyc;
    assign s_STB      = own & m_stb & ~wd_pend;
    assign s_WE       = own & m_we;
    assign s_ADR      = own ? m_adr : '0;
    assign s_SEL      = own ? m_sel : '0;
    assign s_DAT_MOSI = own ? m_dat : '0;

    // A real ACK on the watchdog cycle takes priority over the synthetic one.
    assign wd_fire = own & wd_pend & ~s_ACK;
    assign ack     = own & (s_ACK | wd_pend);
    assign rdata   = wd_fire ? '1 : s_DAT_MISO;

    assign m0_ACK      = own0 & ack;
    assign m1_ACK      = own1 & ack;
    assign m0_DAT_MISO = own0 ? rdata : '0;
    assign m1_DAT_MISO = own1 ? rdata : '0;

    assign wd_wait = own & s_STB & ~s_ACK;

    always_ff @(posedge ctrlCd_clk) begin
        if (ctrlCd_reset) begin
            state          <= IDLE;
            grant          <= 2'b00;
            last           <= 1'b1;
            wd_cnt         <= 8'd0;
            wd_pend        <= 1'b0;
            timeout_sticky <= 1'b0;
        end else begin
            timeout_sticky <= wd_fire | (timeout_sticky & ~timeout_clr);
            wd_pend        <= wd_wait & m_cyc & (wd_cnt == WD_LAST);
            if (wd_wait && wd_cnt != WD_LAST)
                wd_cnt <= wd_cnt + 8'd1;
            else
                wd_cnt <= 8'd0;
            unique case (state)
                IDLE: begin
                    if (req0 && (!req1 || last)) begin
                        state <= OWN0;
                        grant <= 2'b01;
                        last  <= 1'b0;
                    end else if (req1) begin
                        state <= OWN1;
                        grant <= 2'b10;
                        last  <= 1'b1;
                    end
                end
                OWN0: begin
                    if (!m0_CYC) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                OWN1: begin
                    if (!m1_CYC) begin
                        state <= IDLE;
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usbdev_wb_arbiter.sv
// Randomized bench for usbdev_wb_arbiter against a transaction-level owner/wait model.
// Phases vary slave responsiveness, including a dead slave to exercise the watchdog.
module tb_usbdev_wb_arbiter;

    localparam int ADR_W   = 14;
    localparam int DAT_W   = 32;
    localparam int SEL_W   = 4;
    localparam int TIMEOUT = 15;
    localparam int NCYC    = 8000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic             cyc [2];
    logic             stb [2];
    logic             we  [2];
    logic [ADR_W-1:0] adr [2];
    logic [SEL_W-1:0] sel [2];
    logic [DAT_W-1:0] mosi[2];

    logic             m0_ACK, m1_ACK;
    logic [DAT_W-1:0] m0_DAT_MISO, m1_DAT_MISO;
    logic             s_CYC, s_STB, s_WE;
    logic [ADR_W-1:0] s_ADR;
    logic [SEL_W-1:0] s_SEL;
    logic [DAT_W-1:0] s_DAT_MOSI;
    logic             s_ACK;
    logic [DAT_W-1:0] s_DAT_MISO;
    logic             timeout_clr;
    logic             timeout_sticky;
    logic [1:0]       grant;

    usbdev_wb_arbiter #(
        .ADR_W(ADR_W), .DAT_W(DAT_W), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .ctrlCd_clk    (clk),
        .ctrlCd_reset  (rst),
        .m0_CYC        (cyc[0]),
        .m0_STB        (stb[0]),
        .m0_WE         (we[0]),
        .m0_ADR        (adr[0]),
        .m0_SEL        (sel[0]),
        .m0_DAT_MOSI   (mosi[0]),
        .m0_ACK        (m0_ACK),
        .m0_DAT_MISO   (m0_DAT_MISO),
        .m1_CYC        (cyc[1]),
        .m1_STB        (stb[1]),
        .m1_WE         (we[1]),
        .m1_ADR        (adr[1]),
        .m1_SEL        (sel[1]),
        .m1_DAT_MOSI   (mosi[1]),
        .m1_ACK        (m1_ACK),
        .m1_DAT_MISO   (m1_DAT_MISO),
        .s_CYC         (s_CYC),
        .s_STB         (s_STB),
        .s_WE          (s_WE),
        .s_ADR         (s_ADR),
        .s_SEL         (s_SEL),
        .s_DAT_MOSI    (s_DAT_MOSI),
        .s_ACK         (s_ACK),
        .s_DAT_MISO    (s_DAT_MISO),
        .timeout_clr   (timeout_clr),
        .timeout_sticky(timeout_sticky),
        .grant         (grant)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s @%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Model: owner index (-1 idle), last owner, consecutive unanswered strobe cycles.
    int owner;
    int last_own;
    int waits;
    bit pend;
    bit sticky;
    int sticky_cycles;

    task automatic model_reset();
        owner    = -1;
        last_own = 1;
        waits    = 0;
        pend     = 0;
        sticky   = 0;
    endtask

    task automatic check_cycle();
        logic [63:0] e_s, e_m0, e_m1, e_g;
        logic [DAT_W-1:0] rd;
        e_s  = '0;
        e_m0 = '0;
        e_m1 = '0;
        e_g  = '0;
        rd   = (pend && !s_ACK) ? {DAT_W{1'b1}} : s_DAT_MISO;
        if (owner >= 0) begin
            e_s = {11'd0, cyc[owner], stb[owner] & ~pend, we[owner],
                   adr[owner], sel[owner], mosi[owner]};
            e_g = 64'(1) << owner;
            if (owner == 0) e_m0 = {31'd0, s_ACK | pend, rd};
            else            e_m1 = {31'd0, s_ACK | pend, rd};
        end
        chk("slave_bus", {11'd0, s_CYC, s_STB, s_WE, s_ADR, s_SEL, s_DAT_MOSI}, e_s);
        chk("m0_resp", {31'd0, m0_ACK, m0_DAT_MISO}, e_m0);
        chk("m1_resp", {31'd0, m1_ACK, m1_DAT_MISO}, e_m1);
        chk("grant", 64'(grant), e_g);
        chk("sticky", 64'(timeout_sticky), 64'(sticky));
        if (timeout_sticky) sticky_cycles++;
    endtask

    task automatic model_step();
        bit r0, r1, stb_eff;
        int nw;
        if (rst) begin
            model_reset();
            return;
        end
        if (owner >= 0 && pend && !s_ACK) sticky = 1;
        else if (timeout_clr)             sticky = 0;
        if (owner >= 0) begin
            stb_eff = stb[owner] && !pend;
            nw      = (stb_eff && !s_ACK) ? waits + 1 : 0;
            pend    = 0;
            if (nw == TIMEOUT) begin
                nw   = 0;
                pend = 1;
            end
            waits = nw;
            if (!cyc[owner]) begin
                owner = -1;
                pend  = 0;
                waits = 0;
            end
        end else begin
            pend  = 0;
            waits = 0;
            r0    = cyc[0] && stb[0];
            r1    = cyc[1] && stb[1];
            if (r0 && r1)  owner = 1 - last_own;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            if (owner >= 0) last_own = owner;
        end
    endtask

    task automatic drive_random(input int phase);
        bit dead;
        int flip;
        dead = (phase == 2);
        flip = dead ? 63 : 7;
        for (int n = 0; n < 2; n++) begin
            if ($urandom_range(0, flip) == 0) cyc[n] = ~cyc[n];
            stb[n]  = cyc[n] & (dead ? 1'b1 : ($urandom_range(0, 3) != 0));
            we[n]   = 1'($urandom);
            adr[n]  = ADR_W'($urandom);
            sel[n]  = SEL_W'($urandom);
            mosi[n] = $urandom;
        end
        unique case (phase)
            0:       s_ACK = ($urandom_range(0, 1) == 0);
            1:       s_ACK = ($urandom_range(0, 9) == 0);
            2:       s_ACK = ($urandom_range(0, 200) == 0);
            default: s_ACK = ($urandom_range(0, 2) == 0);
        endcase
        s_DAT_MISO  = $urandom;
        timeout_clr = ($urandom_range(0, 31) == 0);
        rst         = ($urandom_range(0, (phase == 3) ? 60 : 400) == 0);
    endtask

    initial begin
        for (int n = 0; n < 2; n++) begin
            cyc[n] = 0; stb[n] = 0; we[n] = 0;
            adr[n] = '0; sel[n] = '0; mosi[n] = '0;
        end
        s_ACK = 0;
        s_DAT_MISO = '0;
        timeout_clr = 0;
        sticky_cycles = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        @(negedge clk);
        chk("reset_grant", 64'(grant), 64'd0);
        chk("reset_stb", 64'({s_CYC, s_STB, m0_ACK, m1_ACK}), 64'd0);
        check_cycle();
        model_step();
        @(posedge clk);
        #1;
        for (int c = 0; c < NCYC; c++) begin
            drive_random((c / 500) % 4);
            @(negedge clk);
            check_cycle();
            model_step();
            @(posedge clk);
            #1;
        end
        chk("watchdog_seen", 64'(sticky_cycles != 0), 64'd1);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
